spi_target: RTL and testbench



---
 rtl/spi_target.sv | 185 ++++++++++++++++++
 tb/tb_spi_target.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_target.sv
// spi_target
//
// SPI target endpoint running entirely in the local clk domain. SCLK, CS_N and
// MOSI are synchronised (two flops) and edge-detected against a history flop,
// so the raw SPI clock never clocks any register. Whole words are exchanged
// with local logic through a TX holding register (valid/ready in) and an RX
// holding register (valid/ready out).
//
// Parameters
//   DATA_WIDTH  bits per SPI word (4..32), MSB first
//   CPOL        SCLK idle level
//   CPHA        0: sample on leading edge, shift on trailing edge
//               1: shift on leading edge, sample on trailing edge
//
// Ports
//   clk, reset                 system clock, synchronous active-high reset
//   sclk_in, cs_n_in, mosi_in  asynchronous SPI inputs from the controller
//   miso_out, miso_oe          target data out and its output enable
//   tx_data/tx_valid/tx_ready  word to transmit, accepted into the holding reg
//   rx_data/rx_valid/rx_ready  last received word, consumed by local logic
//   clear_flags                pulse clearing the sticky flags
//   rx_overflow                word completed while rx_data still unread
//   tx_underflow               word started with no TX word available
//   frame_error                chip select released in the middle of a word
//   busy                       high while the target is selected
module spi_target #(
  parameter int   DATA_WIDTH = 8,
  parameter logic CPOL       = 1'b0,
  parameter logic CPHA       = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sclk_in,
  input  logic                  cs_n_in,
  input  logic                  mosi_in,
  output logic                  miso_out,
  output logic                  miso_oe,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  input  logic                  clear_flags,
  output logic                  rx_overflow,
  output logic                  tx_underflow,
  output logic                  frame_error,
  output logic                  busy
);

  localparam int CNT_W = $clog2(DATA_WIDTH);

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  state_t state, state_nxt;

  // Synchroniser stages: _p0/_p1 form the two-flop synchroniser, _p2 is the
  // history flop used for edge detection. These are deliberately not reset so
  // that, after a reset in the middle of a frame, cs_n is already seen low and
  // no false falling edge re-enters the ongoing frame.
  logic sclk_p0, sclk_p1, sclk_p2;
  logic cs_p0, cs_p1, cs_p2;
  logic mosi_p0, mosi_p1;

  always_ff @(posedge clk) begin
    sclk_p0 <= sclk_in;
    sclk_p1 <= sclk_p0;
    sclk_p2 <= sclk_p1;
    cs_p0   <= cs_n_in;
    cs_p1   <= cs_p0;
    cs_p2   <= cs_p1;
    mosi_p0 <= mosi_in;
    mosi_p1 <= mosi_p0;
  end

  // Edge detection on the synchronised signals
  logic                  cs_fall, cs_rise, selected;
  logic                  lead_edge, trail_edge;
  logic                  sample_edge, shift_edge;
  logic                  load, shift, last_bit, word_done, frame_end;
  logic                  und_set, ovf_set, ferr_set;
  logic [CNT_W-1:0]      bit_cnt;
  logic [DATA_WIDTH-1:0] tx_hold, tx_shift, rx_shift, rx_word;
  logic                  tx_full, und_pend;

  assign cs_fall    = cs_p2 & ~cs_p1;
  assign cs_rise    = ~cs_p2 & cs_p1;
  assign selected   = (state == ACTIVE) && !cs_p1;
  assign lead_edge  = selected && (sclk_p1 != CPOL) && (sclk_p2 == CPOL);
  assign trail_edge = selected && (sclk_p1 == CPOL) && (sclk_p2 != CPOL);

  assign sample_edge = CPHA ? trail_edge : lead_edge;
  assign shift_edge  = CPHA ? lead_edge  : trail_edge;

  // CPHA=0 must present the MSB before the first leading edge, so a word is
  // loaded at cs_n fall and at the trailing edge after each word's last sample
  // (bit_cnt has just wrapped to 0). CPHA=1 loads on a word's first leading edge.
  assign load = CPHA ? (lead_edge && (bit_cnt == '0))
                     : (((state == IDLE) && cs_fall) || (trail_edge && (bit_cnt == '0)));
  assign shift     = shift_edge && !load;
  assign last_bit  = (bit_cnt == CNT_W'(DATA_WIDTH - 1));
  assign word_done = sample_edge && last_bit;
  assign rx_word   = {rx_shift[DATA_WIDTH-2:0], mosi_p1};
  assign frame_end = (state == ACTIVE) && cs_rise;

  // An empty-register load only counts as underflow once the word really
  // starts (its first sample). With CPHA=0 the trailing-edge load after the
  // final word of a frame is speculative and must not raise the flag.
  assign und_set  = sample_edge && (bit_cnt == '0) && und_pend;
  assign ovf_set  = word_done && rx_valid && !rx_ready;
  assign ferr_set = frame_end && (bit_cnt != '0);

  assign miso_out = tx_shift[DATA_WIDTH-1];
  assign miso_oe  = (state == ACTIVE);
  assign busy     = (state == ACTIVE);
  assign tx_ready = !tx_full;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cs_fall) state_nxt = ACTIVE;
      ACTIVE:  if (cs_rise) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Data-only registers: content is qualified by tx_full / bit_cnt.
  always_ff @(posedge clk) begin
    if (tx_valid && !tx_full) tx_hold <= tx_data;
    if (sample_edge)          rx_shift <= rx_word;
  end

  // Shift, holding and flag control
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_full      <= 1'b0;
      tx_shift     <= '0;
      und_pend     <= 1'b0;
      bit_cnt      <= '0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rx_overflow  <= 1'b0;
      tx_underflow <= 1'b0;
      frame_error  <= 1'b0;
    end else begin
      if (load)                 tx_full <= 1'b0;
      if (tx_valid && !tx_full) tx_full <= 1'b1;

      if (und_set) und_pend <= 1'b0;
      if (frame_end) begin
        tx_shift <= '0;
        und_pend <= 1'b0;
      end else if (load) begin
        tx_shift <= tx_full ? tx_hold : '0;
        und_pend <= !tx_full;
      end else if (shift) begin
        tx_shift <= {tx_shift[DATA_WIDTH-2:0], 1'b0};
      end

      if (frame_end)        bit_cnt <= '0;
      else if (sample_edge) bit_cnt <= last_bit ? '0 : bit_cnt + CNT_W'(1);

      // A completion coinciding with rx_ready replaces the word being read.
      if (word_done && (!rx_valid || rx_ready)) begin
        rx_data  <= rx_word;
        rx_valid <= 1'b1;
      end else if (rx_ready) begin
        rx_valid <= 1'b0;
      end

      rx_overflow  <= (rx_overflow  && !clear_flags) || ovf_set;
      tx_underflow <= (tx_underflow && !clear_flags) || und_set;
      frame_error  <= (frame_error  && !clear_flags) || ferr_set;
    end
  end

endmodule

// File: tb/tb_spi_target.sv
// Bench for spi_target: one instance per SPI mode (index = CPOL*2 + CPHA).
// A controller model drives SCLK/CS_N/MOSI on one instance at a time and
// collects MISO; a transaction-level model predicts received words, sticky
// flags and MISO words, and a monitor pops expected RX words on each handshake.
module tb_spi_target;
  localparam int W  = 8;
  localparam int HP = 4;   // SCLK half period in clk cycles (clk:SCLK = 8:1)

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic clear_flags = 1'b0;

  logic         sclk[4], cs_n[4], mosi[4], tx_valid[4], rx_ready[4];
  logic [W-1:0] tx_data[4];
  logic         miso[4], miso_oe[4], tx_ready[4], rx_valid[4];
  logic         ovf[4], und[4], ferr[4], busy[4];
  logic [W-1:0] rx_data[4];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    spi_target #(.DATA_WIDTH(W), .CPOL(1'(g / 2)), .CPHA(1'(g % 2))) dut (
      .clk(clk), .reset(reset),
      .sclk_in(sclk[g]), .cs_n_in(cs_n[g]), .mosi_in(mosi[g]),
      .miso_out(miso[g]), .miso_oe(miso_oe[g]),
      .tx_data(tx_data[g]), .tx_valid(tx_valid[g]), .tx_ready(tx_ready[g]),
      .rx_data(rx_data[g]), .rx_valid(rx_valid[g]), .rx_ready(rx_ready[g]),
      .clear_flags(clear_flags),
      .rx_overflow(ovf[g]), .tx_underflow(und[g]), .frame_error(ferr[g]),
      .busy(busy[g])
    );
  end

  // Reference model state
  logic [W-1:0] exp_rx[4][$];
  logic [W-1:0] m_txq[4][$];
  bit           mvalid[4], m_ovf[4], m_und[4], m_ferr[4];
  bit           auto_rd;
  logic [W-1:0] ctrl_w[4];
  int           errors = 0;
  int           checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // RX scoreboard monitor
  always @(negedge clk) begin
    for (int m = 0; m < 4; m++) begin
      if (!reset && rx_valid[m] && rx_ready[m]) begin
        if (exp_rx[m].size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rx_unexpected m%0d: got %0h expected no word", m, rx_data[m]);
        end else begin
          chk($sformatf("rx_word m%0d", m), 32'(rx_data[m]), 32'(exp_rx[m].pop_front()));
        end
      end
    end
  end

  task automatic model_reset();
    for (int m = 0; m < 4; m++) begin
      exp_rx[m].delete();
      m_txq[m].delete();
      mvalid[m] = 0; m_ovf[m] = 0; m_und[m] = 0; m_ferr[m] = 0;
    end
  endtask

  task automatic push_tx(input int m, input logic [W-1:0] v);
    int t = 0;
    while (!tx_ready[m] && t < 200) begin
      cyc(1);
      t++;
    end
    chk($sformatf("tx_ready_wait m%0d", m), 32'(tx_ready[m]), 32'd1);
    tx_data[m]  = v;
    tx_valid[m] = 1'b1;
    cyc(1);
    tx_valid[m] = 1'b0;
    m_txq[m].push_back(v);
  endtask

  task automatic spi_bit(input int m, input logic bo, output logic bi);
    logic cpol, cpha;
    cpol = (m >= 2);
    cpha = ((m % 2) == 1);
    if (!cpha) begin
      mosi[m] = bo;
      bi = miso[m];
      sclk[m] = ~cpol; cyc(HP);
      sclk[m] = cpol;  cyc(HP);
    end else begin
      sclk[m] = ~cpol;
      mosi[m] = bo;
      cyc(HP);
      bi = miso[m];
      sclk[m] = cpol;  cyc(HP);
    end
  endtask

  // nw words from ctrl_w; the last word is cut to last_bits bits
  task automatic frame(input int m, input int nw, input int last_bits);
    cs_n[m] = 1'b0;
    cyc(HP);
    for (int w = 0; w < nw; w++) begin
      int nb;
      logic [W-1:0] got, etx;
      logic bi;
      nb  = (w == nw - 1) ? last_bits : W;
      got = '0;
      if (m_txq[m].size() > 0) etx = m_txq[m].pop_front();
      else begin
        etx = '0;
        m_und[m] = 1;
      end
      if (nb == W) begin
        if (auto_rd) exp_rx[m].push_back(ctrl_w[w]);
        else if (mvalid[m]) m_ovf[m] = 1;
        else begin
          exp_rx[m].push_back(ctrl_w[w]);
          mvalid[m] = 1;
        end
      end else begin
        m_ferr[m] = 1;
      end
      for (int b = 0; b < nb; b++) begin
        spi_bit(m, ctrl_w[w][W-1-b], bi);
        got = {got[W-2:0], bi};
      end
      if (nb == W) chk($sformatf("miso m%0d w%0d", m, w), 32'(got), 32'(etx));
    end
    cs_n[m] = 1'b1;
    cyc(HP);
  endtask

  task automatic xfer(input int m, input int n, input logic [W-1:0] t1,
                      input logic [W-1:0] t2, input bit autor);
    auto_rd = autor;
    rx_ready[m] = autor;
    push_tx(m, t1);
    if (n == 2) begin
      fork
        frame(m, 2, W);
        begin
          cyc(8);
          push_tx(m, t2);
        end
      join
    end else begin
      frame(m, 1, W);
    end
    cyc(6);
    rx_ready[m] = 1'b0;
    auto_rd = 0;
  endtask

  task automatic read_rx(input int m);
    int t = 0;
    while (!rx_valid[m] && t < 50) begin
      cyc(1);
      t++;
    end
    chk($sformatf("rx_valid_wait m%0d", m), 32'(rx_valid[m]), 32'd1);
    rx_ready[m] = 1'b1;
    cyc(1);
    rx_ready[m] = 1'b0;
    mvalid[m] = 0;
    cyc(1);
  endtask

  task automatic chk_state(input int m, input string tag);
    chk($sformatf("%s ovf m%0d", tag, m), 32'(ovf[m]), 32'(m_ovf[m]));
    chk($sformatf("%s und m%0d", tag, m), 32'(und[m]), 32'(m_und[m]));
    chk($sformatf("%s ferr m%0d", tag, m), 32'(ferr[m]), 32'(m_ferr[m]));
    chk($sformatf("%s rx_valid m%0d", tag, m), 32'(rx_valid[m]), 32'(mvalid[m]));
    chk($sformatf("%s busy m%0d", tag, m), 32'(busy[m]), 32'd0);
    chk($sformatf("%s miso_oe m%0d", tag, m), 32'(miso_oe[m]), 32'd0);
  endtask

  task automatic chk_reset(input int m, input string tag);
    chk($sformatf("%s miso m%0d", tag, m), 32'(miso[m]), 32'd0);
    chk($sformatf("%s miso_oe m%0d", tag, m), 32'(miso_oe[m]), 32'd0);
    chk($sformatf("%s tx_ready m%0d", tag, m), 32'(tx_ready[m]), 32'd1);
    chk($sformatf("%s rx_valid m%0d", tag, m), 32'(rx_valid[m]), 32'd0);
    chk($sformatf("%s rx_data m%0d", tag, m), 32'(rx_data[m]), 32'd0);
    chk($sformatf("%s flags m%0d", tag, m), 32'({ovf[m], und[m], ferr[m]}), 32'd0);
    chk($sformatf("%s busy m%0d", tag, m), 32'(busy[m]), 32'd0);
  endtask

  task automatic do_clear();
    clear_flags = 1'b1;
    cyc(1);
    clear_flags = 1'b0;
    for (int m = 0; m < 4; m++) begin
      m_ovf[m] = 0; m_und[m] = 0; m_ferr[m] = 0;
    end
    cyc(1);
  endtask

  initial begin
    #400000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    logic bi;
    for (int m = 0; m < 4; m++) begin
      sclk[m] = (m >= 2); cs_n[m] = 1'b1; mosi[m] = 1'b0;
      tx_valid[m] = 1'b0; rx_ready[m] = 1'b0; tx_data[m] = '0;
    end
    auto_rd = 0;
    model_reset();
    cyc(6);
    reset = 1'b0;
    cyc(2);
    for (int m = 0; m < 4; m++) chk_reset(m, "por");

    // Mode 0 basic exchange
    ctrl_w[0] = 8'h3C;
    xfer(0, 1, 8'hA5, 8'h00, 0);
    chk("basic rx_data", 32'(rx_data[0]), 32'(exp_rx[0][0]));
    chk_state(0, "basic");
    read_rx(0);

    // All modes: fixed 0x81/0x7E exchange plus random one- and two-word frames
    for (int m = 0; m < 4; m++) begin
      ctrl_w[0] = 8'h81;
      xfer(m, 1, 8'h7E, 8'h00, 1);
      chk($sformatf("drain fixed m%0d", m), 32'(exp_rx[m].size()), 32'd0);
      for (int r = 0; r < 3; r++) begin
        int n;
        n = (r == 2) ? 2 : 1;
        ctrl_w[0] = W'($urandom);
        ctrl_w[1] = W'($urandom);
        xfer(m, n, W'($urandom), W'($urandom), 1);
        chk($sformatf("drain rand m%0d", m), 32'(exp_rx[m].size()), 32'd0);
      end
      chk_state(m, "modes");
    end

    // Back-to-back words with continuous reading
    ctrl_w[0] = 8'h11; ctrl_w[1] = 8'h22;
    xfer(0, 2, 8'hF0, 8'h0F, 1);
    chk("b2b drain", 32'(exp_rx[0].size()), 32'd0);
    chk_state(0, "b2b");

    // Overflow: second word lands on an unread first word
    ctrl_w[0] = 8'h11; ctrl_w[1] = 8'h22;
    xfer(0, 2, W'($urandom), W'($urandom), 0);
    chk("ovf rx_data", 32'(rx_data[0]), 32'(exp_rx[0][0]));
    chk_state(0, "ovf");
    do_clear();
    chk_state(0, "ovf_clr");
    read_rx(0);

    // Underflow: no TX preload; word left unread for the reset test
    ctrl_w[0] = W'($urandom_range(1, 255));
    auto_rd = 0;
    frame(0, 1, W);
    cyc(4);
    chk_state(0, "und");

    // Reset in the middle of a frame
    push_tx(0, 8'h5A);
    cs_n[0] = 1'b0;
    cyc(HP);
    push_tx(0, 8'hC3);
    for (int b = 0; b < 3; b++) spi_bit(0, 1'b1, bi);
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    chk_reset(0, "midrst");
    model_reset();
    for (int b = 0; b < 5; b++) spi_bit(0, 1'b1, bi);
    chk("midrst ignored busy", 32'(busy[0]), 32'd0);
    cs_n[0] = 1'b1;
    cyc(HP);
    chk_state(0, "midrst_end");

    // Frame error then a clean frame
    ctrl_w[0] = W'($urandom);
    auto_rd = 0;
    push_tx(0, W'($urandom));
    frame(0, 1, 5);
    cyc(4);
    chk_state(0, "ferr");
    ctrl_w[0] = 8'h55;
    xfer(0, 1, W'($urandom), 8'h00, 0);
    chk("post_ferr rx_data", 32'(rx_data[0]), 32'h55);
    chk_state(0, "post_ferr");
    read_rx(0);
    do_clear();
    chk_state(0, "final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
